// File: rtl/seq_stage_sequencer.sv
// -----------------------------------------------------------------------------
// seq_stage_sequencer
//   Multi-cycle control FSM for the SEQ Y86 core. Steps one instruction through
//   FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD with exactly one stage
//   enable active at a time. It waits on the data-memory handshake (bounded by
//   MEM_TIMEOUT) and tracks processor status (1=AOK, 2=HLT, 3=ADR, 4=INS).
//
// Configuration macro: SEQ_PERF_CNT_EN
//   When defined, adds the CNT_W parameter plus the cycle_cnt/instr_cnt
//   performance counter outputs. When undefined, they do not exist.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst_n        in   synchronous active-low reset
//   run          in   execute request, sampled in IDLE and at the end of PCUPD
//   icode[3:0]   in   fetched instruction code, sampled in FETCH
//   imem_error   in   instruction-fetch address error, sampled in FETCH
//   dmem_ack     in   data-memory access complete (1-cycle pulse)
//   dmem_error   in   data-memory address error, valid with dmem_ack
//   fetch_en, decode_en, exec_en, wb_en, pc_en  out  one-hot stage enables
//   dmem_req     out  data-memory request, high in MEMORY for memory icodes
//   icode_q[3:0] out  icode latched in FETCH
//   stat[2:0]    out  processor status
//   busy         out  high in every state except IDLE and HALT
//   cycle_cnt    out  (SEQ_PERF_CNT_EN) busy-cycle counter
//   instr_cnt    out  (SEQ_PERF_CNT_EN) retired-instruction counter
// -----------------------------------------------------------------------------
module seq_stage_sequencer #(
  parameter int MEM_TIMEOUT = 16
`ifdef SEQ_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic             dmem_req,
  output logic [3:0]       icode_q,
  output logic [2:0]       stat,
  output logic             busy
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t           r_state;
  logic [3:0]       r_icode_q;
  logic [2:0]       r_stat;
  logic [TMO_W-1:0] r_tmo;

  logic w_mem_op;
  logic w_fetch_en;
  logic w_decode_en;
  logic w_exec_en;
  logic w_wb_en;
  logic w_pc_en;
  logic w_dmem_req;
  logic w_busy;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  function automatic logic is_mem_icode(input logic [3:0] c);
    case (c)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_icode = 1'b1;
      default:                            is_mem_icode = 1'b0;
    endcase
  endfunction

  assign w_mem_op = is_mem_icode(r_icode_q);

  // Main sequencer: state, latched icode, status and memory-wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_icode_q <= 4'h0;
      r_stat    <= STAT_AOK;
      r_tmo     <= {TMO_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
          else     r_state <= S_IDLE;
        end
        S_FETCH: begin
          r_icode_q <= icode;
          if (imem_error) begin
            r_stat  <= STAT_ADR;
            r_state <= S_HALT;
          end else if (icode > 4'hB) begin
            r_stat  <= STAT_INS;
            r_state <= S_HALT;
          end else begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (r_icode_q == 4'h0) begin
            r_stat  <= STAT_HLT;
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Clear the wait counter so MEMORY always starts counting from zero.
          r_tmo   <= {TMO_W{1'b0}};
          r_state <= S_MEM;
        end
        S_MEM: begin
          if (!w_mem_op) begin
            r_state <= S_WB;
          end else if (dmem_ack) begin
            // An ack in the final allowed cycle still counts as on time.
            if (dmem_error) begin
              r_stat  <= STAT_ADR;
              r_state <= S_HALT;
            end else begin
              r_state <= S_WB;
            end
          end else if (r_tmo == TMO_LAST) begin
            r_stat  <= STAT_ADR;
            r_state <= S_HALT;
          end else begin
            if (r_tmo != TMO_MAX) r_tmo <= r_tmo + TMO_ONE;
            else                  r_tmo <= r_tmo;
          end
        end
        S_WB: begin
          r_state <= S_PCUPD;
        end
        S_PCUPD: begin
          if (run) r_state <= S_FETCH;
          else     r_state <= S_IDLE;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage enables, memory request and busy decoded from the state register only.
  always_comb begin
    w_fetch_en  = 1'b0;
    w_decode_en = 1'b0;
    w_exec_en   = 1'b0;
    w_wb_en     = 1'b0;
    w_pc_en     = 1'b0;
    w_dmem_req  = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE:   w_busy      = 1'b0;
      S_FETCH:  w_fetch_en  = 1'b1;
      S_DECODE: w_decode_en = 1'b1;
      S_EXEC:   w_exec_en   = 1'b1;
      S_MEM:    w_dmem_req  = w_mem_op;
      S_WB:     w_wb_en     = 1'b1;
      S_PCUPD:  w_pc_en     = 1'b1;
      S_HALT:   w_busy      = 1'b0;
      default:  w_busy      = 1'b0;
    endcase
  end

  assign fetch_en  = w_fetch_en;
  assign decode_en = w_decode_en;
  assign exec_en   = w_exec_en;
  assign wb_en     = w_wb_en;
  assign pc_en     = w_pc_en;
  assign dmem_req  = w_dmem_req;
  assign busy      = w_busy;
  assign icode_q   = r_icode_q;
  assign stat      = r_stat;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  // Free-running performance counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt <= {CNT_W{1'b0}};
      r_instr_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_busy)             r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      else                    r_cycle_cnt <= r_cycle_cnt;
      if (r_state == S_PCUPD) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
      else                    r_instr_cnt <= r_instr_cnt;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_seq_stage_sequencer
//   Self-checking bench for seq_stage_sequencer. Each instruction is described
//   at transaction level (icode, fetch error, ack cycle, ack error, next run);
//   the bench expands it into the expected per-cycle stage sequence and checks
//   the DUT outputs cycle by cycle. Directed cases come first, then random.
// -----------------------------------------------------------------------------
module tb_seq_stage_sequencer;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [3:0]  icode;
  logic        imem_error;
  logic        dmem_ack;
  logic        dmem_error;
  logic        fetch_en, decode_en, exec_en, wb_en, pc_en;
  logic        dmem_req;
  logic [3:0]  icode_q;
  logic [2:0]  stat;
  logic        busy;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  seq_stage_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .icode      (icode),
    .imem_error (imem_error),
    .dmem_ack   (dmem_ack),
    .dmem_error (dmem_error),
    .fetch_en   (fetch_en),
    .decode_en  (decode_en),
    .exec_en    (exec_en),
    .wb_en      (wb_en),
    .pc_en      (pc_en),
    .dmem_req   (dmem_req),
    .icode_q    (icode_q),
    .stat       (stat),
    .busy       (busy)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          n_vec;
  int          n_err;
  logic [3:0]  m_icq;
  logic [2:0]  m_stat;
  logic [31:0] m_cyc;
  logic [31:0] m_ins;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {fetch,decode,exec,wb,pc,req,busy,stat,icode_q}.
  // Stage numbering: 0 idle, 1 fetch, 2 decode, 3 execute, 4 memory,
  // 5 writeback, 6 pc update, 7 halt.
  function automatic logic [13:0] ev(input int stg, input logic req);
    logic bsy;
    bsy = (stg != 0) && (stg != 7);
    return {stg == 1, stg == 2, stg == 3, stg == 5, stg == 6, req, bsy, m_stat, m_icq};
  endfunction

  // Check the current cycle, then advance one clock and update counter model.
  task automatic expect_cycle(input string tag, input int stg, input logic req);
    logic rst_seen;
    check_val(tag, {18'h0, fetch_en, decode_en, exec_en, wb_en, pc_en, dmem_req, busy, stat, icode_q},
              {18'h0, ev(stg, req)});
`ifdef SEQ_PERF_CNT_EN
    check_val({tag, "_cycle_cnt"}, cycle_cnt, m_cyc);
    check_val({tag, "_instr_cnt"}, instr_cnt, m_ins);
`endif
    rst_seen = !rst_n;
    @(posedge clk);
    #1;
    if (rst_seen) begin
      m_cyc = 32'd0;
      m_ins = 32'd0;
    end else begin
      if (stg != 0 && stg != 7) m_cyc = m_cyc + 32'd1;
      if (stg == 6)             m_ins = m_ins + 32'd1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b1;
    dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    run      = 1'b0;
    dmem_ack = 1'b0;
    m_icq  = 4'h0;
    m_stat = 3'd1;
    m_cyc  = 32'd0;
    m_ins  = 32'd0;
    expect_cycle("reset", 0, 1'b0);
  endtask

  // From IDLE, request execution; DUT ends up in FETCH.
  task automatic go_fetch();
    run = 1'b1;
    dmem_ack = 1'($urandom);
    expect_cycle("idle_go", 0, 1'b0);
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0;
      dmem_ack = 1'($urandom);
      icode = 4'($urandom);
      expect_cycle("idle_hold", 0, 1'b0);
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      run = (i < 4) ? 1'b1 : 1'($urandom);
      dmem_ack = 1'($urandom);
      dmem_error = 1'($urandom);
      icode = 4'($urandom);
      imem_error = 1'($urandom);
      expect_cycle("halt_hold", 7, 1'b0);
    end
  endtask

  // One instruction starting in FETCH. d = MEMORY cycle carrying the ack
  // (0 = never). res: 0 back in FETCH, 1 parked in IDLE, 2 halted, 3 reset.
  task automatic run_instr(input logic [3:0] ic, input logic ierr, input int d,
                           input logic derr, input logic run_next, input int rst_k,
                           output int res);
    logic [15:0] mem_set;
    logic        done;
    mem_set = 16'h0F30;
    done    = 1'b0;

    icode = ic; imem_error = ierr; run = 1'($urandom);
    dmem_ack = 1'($urandom); dmem_error = 1'($urandom);
    expect_cycle("fetch", 1, 1'b0);
    m_icq = ic;
    icode = 4'($urandom); imem_error = 1'($urandom);
    if (ierr) begin m_stat = 3'd3; res = 2; return; end
    if (ic > 4'hB) begin m_stat = 3'd4; res = 2; return; end

    run = 1'($urandom); dmem_ack = 1'($urandom);
    expect_cycle("decode", 2, 1'b0);
    if (ic == 4'h0) begin m_stat = 3'd2; res = 2; return; end

    run = 1'($urandom); dmem_ack = 1'($urandom);
    expect_cycle("execute", 3, 1'b0);

    if (mem_set[ic]) begin
      for (int k = 1; k <= TMO; k++) begin
        dmem_ack   = (k == d);
        dmem_error = (k == d) ? derr : 1'($urandom);
        run   = 1'($urandom);
        icode = 4'($urandom);
        if (k == rst_k) rst_n = 1'b0;
        expect_cycle("memory", 4, 1'b1);
        dmem_ack = 1'b0;
        if (k == rst_k) begin
          rst_n = 1'b1; m_icq = 4'h0; m_stat = 3'd1; res = 3; return;
        end
        if (k == d) begin
          if (derr) begin m_stat = 3'd3; res = 2; return; end
          done = 1'b1;
          break;
        end
      end
      if (!done) begin m_stat = 3'd3; res = 2; return; end
    end else begin
      dmem_ack = 1'($urandom); dmem_error = 1'($urandom);
      expect_cycle("memory_nop", 4, 1'b0);
    end

    run = 1'($urandom); dmem_ack = 1'($urandom);
    expect_cycle("writeback", 5, 1'b0);
    run = run_next; dmem_ack = 1'($urandom);
    expect_cycle("pcupd", 6, 1'b0);
    res = run_next ? 0 : 1;
  endtask

  task automatic do_instr(input logic [3:0] ic, input logic ierr, input int d,
                          input logic derr, input logic run_next, input int rst_k,
                          input int hold);
    int res;
    run_instr(ic, ierr, d, derr, run_next, rst_k, res);
    case (res)
      1: begin idle_hold(1 + int'($urandom % 3)); go_fetch(); end
      2: begin halt_hold(hold); do_reset(); go_fetch(); end
      3: go_fetch();
      default: ;
    endcase
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; run = 1'b0; icode = 4'h0;
    imem_error = 1'b0; dmem_ack = 1'b0; dmem_error = 1'b0;
    m_icq = 4'h0; m_stat = 3'd1; m_cyc = 32'd0; m_ins = 32'd0;

    do_reset();
    idle_hold(2);
    go_fetch();

    // Directed: ic, imem_err, ack cycle, ack err, next run, reset cycle, halt hold
    do_instr(4'h6, 1'b0, 0,  1'b0, 1'b1, 0, 0);   // OPq, 6 cycles
    do_instr(4'h6, 1'b0, 0,  1'b0, 1'b1, 0, 0);
    do_instr(4'h5, 1'b0, 3,  1'b0, 1'b1, 0, 0);   // mrmovq, ack in 3rd MEMORY cycle
    do_instr(4'h8, 1'b0, 1,  1'b0, 1'b1, 0, 0);   // ack in entry cycle
    do_instr(4'h9, 1'b0, TMO, 1'b0, 1'b1, 0, 0);  // ack in last allowed cycle
    do_instr(4'h4, 1'b0, 2,  1'b1, 1'b1, 0, 4);   // data error -> ADR
    do_instr(4'hA, 1'b0, 0,  1'b0, 1'b1, 0, 4);   // timeout -> ADR
    do_instr(4'h0, 1'b0, 0,  1'b0, 1'b1, 0, 20);  // halt -> HLT, hold 20 cycles
    do_instr(4'hC, 1'b0, 0,  1'b0, 1'b1, 0, 3);   // invalid -> INS
    do_instr(4'hF, 1'b0, 0,  1'b0, 1'b1, 0, 3);
    do_instr(4'h3, 1'b1, 0,  1'b0, 1'b1, 0, 3);   // fetch error -> ADR
    do_instr(4'hB, 1'b0, 10, 1'b0, 1'b1, 2, 0);   // reset while requesting
    do_instr(4'h6, 1'b0, 0,  1'b0, 1'b0, 0, 0);   // run drops, park in IDLE
    do_instr(4'h2, 1'b0, 0,  1'b0, 1'b1, 0, 0);

    // Random instructions
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ic;
      logic       ierr;
      int         d;
      int         rk;
      ic   = ($urandom % 8 == 0) ? 4'($urandom) : 4'(1 + $urandom % 11);
      ierr = ($urandom % 16 == 0);
      d    = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, TMO));
      rk   = ($urandom % 20 == 0) ? int'($urandom_range(1, 3)) : 0;
      do_instr(ic, ierr, d, ($urandom % 8 == 0), ($urandom % 4 != 0), rk,
               int'($urandom_range(1, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
